fir_mac_seq: RTL and testbench

//  Time-multiplexed N-tap FIR filter: consumes the 24-bit signed 2 kHz sample stream

---
 rtl/fir_mac_seq.sv | 137 +++++++++++++
 tb/tb_fir_mac_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// Time-multiplexed N-tap FIR: one multiplier walks a circular sample buffer
// against runtime-writable Q2.16 coefficients, then rounds and saturates.
module fir_mac_seq #(
    parameter int TAPS  = 16,
    parameter int DW    = 24,
    parameter int CW    = 18,
    parameter int SHIFT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [DW-1:0]      data_in,
    input  logic                      data_in_valid,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [CW-1:0]      coef_data,
    output logic signed [DW-1:0]      data_out,
    output logic                      data_out_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int AW    = $clog2(TAPS);
    localparam int PW    = DW + CW;
    localparam int ACC_W = DW + CW + AW;

    localparam logic signed [CW-1:0] COEF_ONE = CW'(64'(1) << SHIFT);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(64'(1) << (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'(1) << (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - 1;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic signed [DW-1:0] xbuf [TAPS];
    logic signed [CW-1:0] hbuf [TAPS];

    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           k;
    logic [AW-1:0]           rd_idx;
    logic signed [PW-1:0]    mult;
    logic signed [PW-1:0]    prod;
    logic                    prod_vld;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] rnd;
    logic signed [DW-1:0]    sat;
    logic                    fin;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (data_in_valid) state_nx = MAC;
            MAC:  if (k == AW'(TAPS - 1)) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign rd_idx  = wr_ptr - k;
    assign mult    = xbuf[rd_idx] * hbuf[k];
    assign acc_sum = acc + $signed({{AW{prod[PW-1]}}, prod});

    // Round half toward +inf, then clamp to the output range.
    always_comb begin
        rnd = (acc + HALF) >>> SHIFT;
        sat = rnd[DW-1:0];
        if (rnd > SAT_HI) sat = SAT_HI[DW-1:0];
        else if (rnd < SAT_LO) sat = SAT_LO[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            k              <= '0;
            prod           <= '0;
            prod_vld       <= 1'b0;
            acc            <= '0;
            fin            <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overrun        <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                xbuf[i] <= '0;
                hbuf[i] <= (i == 0) ? COEF_ONE : '0;
            end
        end else begin
            state          <= state_nx;
            data_out_valid <= 1'b0;
            fin            <= 1'b0;

            if (fin) begin
                data_out       <= sat;
                data_out_valid <= 1'b1;
            end

            if (data_in_valid && state != IDLE)
                overrun <= 1'b1;

            if (coef_we && state == IDLE)
                hbuf[coef_addr] <= coef_data;

            // Product is registered, so accumulation trails the tap index by one.
            unique case (state)
                IDLE: begin
                    if (data_in_valid) begin
                        xbuf[wr_ptr] <= data_in;
                        acc          <= '0;
                        k            <= '0;
                        prod_vld     <= 1'b0;
                    end
                end
                MAC: begin
                    prod     <= mult;
                    prod_vld <= 1'b1;
                    k        <= k + 1'b1;
                    if (prod_vld) acc <= acc_sum;
                end
                DONE: begin
                    acc      <= acc_sum;
                    prod_vld <= 1'b0;
                    wr_ptr   <= wr_ptr + 1'b1;
                    fin      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq: passthrough, impulse, saturation,
// rounding, overrun and a generator stream with a mid-MAC reset.
module tb_fir_mac_seq;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [23:0] data_in = '0;
    logic               data_in_valid = 1'b0;
    logic               coef_we = 1'b0;
    logic [3:0]         coef_addr = '0;
    logic signed [17:0] coef_data = '0;
    logic signed [23:0] data_out;
    logic               data_out_valid;
    logic               busy;
    logic               overrun;

    int checks = 0;
    int errors = 0;

    fir_mac_seq dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .coef_we        (coef_we),
        .coef_addr      (coef_addr),
        .coef_data      (coef_data),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic reset_dut();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic write_coef(input int a, input int v);
        @(posedge clk); #1;
        coef_we = 1'b1; coef_addr = 4'(a); coef_data = 18'(v);
        @(posedge clk); #1 coef_we = 1'b0;
    endtask

    // Feeds one sample, returns output, latency in edges (-1 on timeout), busy after accept.
    task automatic run_sample(input logic signed [23:0] s,
                              output logic signed [23:0] got,
                              output int lat, output logic bsy);
        @(posedge clk); #1;
        data_in = s; data_in_valid = 1'b1;
        @(posedge clk); #1 data_in_valid = 1'b0;
        bsy = busy;
        lat = -1;
        got = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (data_out_valid) begin
                lat = c; got = data_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (data_out !== 24'sd0) begin errors++; $display("FAIL reset_data_out got %0d want 0", data_out); end
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask

    task automatic test_passthrough();
        logic signed [23:0] vec [4];
        logic signed [23:0] got;
        int lat;
        logic b;
        vec[0] = 24'sd1000; vec[1] = -24'sd1000;
        vec[2] = 24'h7FFFFF; vec[3] = 24'h800000;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            run_sample(vec[i], got, lat, b);
            checks++; if (got !== vec[i]) begin errors++; $display("FAIL pass_value[%0d] got %0d want %0d", i, got, vec[i]); end
            checks++; if (lat !== 18) begin errors++; $display("FAIL pass_latency[%0d] got %0d want 18", i, lat); end
            checks++; if (b !== 1'b1) begin errors++; $display("FAIL pass_busy[%0d] got %b want 1", i, b); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pass_idle[%0d] got %b want 0", i, busy); end
        end
    endtask

    task automatic test_impulse();
        logic signed [23:0] got;
        int lat;
        logic b;
        reset_dut();
        for (int k = 0; k < 16; k++) write_coef(k, 4096 * k);
        for (int n = 0; n < 16; n++) begin
            run_sample((n == 0) ? 24'sd65536 : 24'sd0, got, lat, b);
            checks++; if (got !== 24'(4096 * n) || lat !== 18) begin
                errors++; $display("FAIL impulse[%0d] got %0d lat %0d want %0d lat 18", n, got, lat, 4096 * n);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [23:0] got;
        int lat;
        logic b;
        reset_dut();
        for (int k = 0; k < 16; k++) write_coef(k, 65536);
        for (int n = 0; n < 16; n++) run_sample(24'h7FFFFF, got, lat, b);
        checks++; if (got !== 24'h7FFFFF) begin errors++; $display("FAIL sat_pos got %h want 7fffff", got); end
        for (int n = 0; n < 16; n++) run_sample(24'h800000, got, lat, b);
        checks++; if (got !== 24'h800000) begin errors++; $display("FAIL sat_neg got %h want 800000", got); end
    endtask

    task automatic test_rounding();
        logic signed [23:0] in_v [3];
        logic signed [23:0] exp_v [3];
        logic signed [23:0] got;
        int lat;
        logic b;
        in_v[0] = 24'sd3;  exp_v[0] = 24'sd2;
        in_v[1] = -24'sd3; exp_v[1] = -24'sd1;
        in_v[2] = 24'sd1;  exp_v[2] = 24'sd1;
        reset_dut();
        write_coef(0, 32768);
        for (int i = 0; i < 3; i++) begin
            run_sample(in_v[i], got, lat, b);
            checks++; if (got !== exp_v[i]) begin errors++; $display("FAIL round[%0d] got %0d want %0d", i, got, exp_v[i]); end
        end
    endtask

    task automatic test_overrun();
        logic signed [23:0] got;
        int lat;
        logic b;
        reset_dut();
        @(posedge clk); #1;
        data_in = 24'sd1000; data_in_valid = 1'b1;
        @(posedge clk); #1 data_in_valid = 1'b0;
        lat = -1; got = 'x;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin data_in = 24'sd2000; data_in_valid = 1'b1; end
            if (c == 7) begin coef_we = 1'b1; coef_addr = 4'd0; coef_data = 18'sd0; end
            @(posedge clk); #1;
            data_in_valid = 1'b0; coef_we = 1'b0;
            if (data_out_valid) begin lat = c; got = data_out; break; end
        end
        checks++; if (got !== 24'sd1000) begin errors++; $display("FAIL ovr_first got %0d want 1000", got); end
        checks++; if (lat !== 18) begin errors++; $display("FAIL ovr_latency got %0d want 18", lat); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
        run_sample(24'sd7, got, lat, b);
        checks++; if (got !== 24'sd7) begin errors++; $display("FAIL ovr_coef_kept got %0d want 7", got); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    function automatic logic signed [23:0] gen(input int i);
        real p;
        p = 2.0 * 3.14159265358979 * real'(i % 40) / 40.0;
        return 24'($rtoi(3000000.0 * $sin(p) + 1000000.0 * $sin(5.0 * p)));
    endfunction

    task automatic test_stream();
        logic signed [23:0] got;
        logic signed [23:0] s;
        int lat;
        logic b;
        logic seen;
        reset_dut();
        for (int i = 0; i < 100; i++) begin
            s = gen(i);
            if (i == 50) begin
                @(posedge clk); #1;
                data_in = s; data_in_valid = 1'b1;
                @(posedge clk); #1 data_in_valid = 1'b0;
                repeat (5) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
                seen = 1'b0;
                for (int c = 0; c < 25; c++) begin
                    @(posedge clk); #1;
                    if (data_out_valid || data_out !== 24'sd0) seen = 1'b1;
                end
                checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stream_abort got activity want none"); end
            end else begin
                run_sample(s, got, lat, b);
                checks++; if (got !== s || lat !== 18) begin
                    errors++; $display("FAIL stream[%0d] got %0d lat %0d want %0d lat 18", i, got, lat, s);
                end
                repeat (3) @(posedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_impulse();
        test_saturation();
        test_rounding();
        test_overrun();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
